packet_stream_reader: RTL and testbench
=======================================

// Module: packet_stream_reader
// PURPOSE
//  Drains packets from the read side of a packet_buffer instance and emits each as a word
//  stream (valid/ready, byte keep, last) toward the MAC transmit datapath. Issues word reads,
//  absorbs the 1-cycle sync-RAM read latency in a 3-entry output FIFO, and acks the slot after
//  the final beat is accepted. Drops and acks illegal-size packets without emitting beats.
// PARAMETERS
//  data_width_p     64    stream/buffer word width; only 32 or 64 are legal
//  els_p            2048  bytes per buffer slot
//  addr_width_lp    $clog2(els_p)           byte address width (localparam)
//  size_width_lp    $clog2(els_p+1)         packet size width (localparam)
//  bytes_lp         data_width_p/8          bytes per word (localparam)
// PORTS
//  clk_i            in   1               clock
//  reset_i          in   1               synchronous, active-high reset
//  packet_avail_i   in   1               buffer read slot holds a packet
//  packet_rsize_i   in   size_width_lp   byte size of that packet; valid while packet_avail_i
//  packet_ack_o     out  1               1-cycle pulse: free the current read slot
//  packet_rvalid_o  out  1               word read request this cycle
//  packet_raddr_o   out  addr_width_lp   byte address of read; always word-aligned
//  packet_rdata_i   in   data_width_p    read data, valid the cycle after packet_rvalid_o
//  tx_valid_o       out  1               stream beat valid
//  tx_data_o        out  data_width_p    beat data; byte 0 = lowest-addressed byte
//  tx_keep_o        out  bytes_lp        valid-byte mask, LSB-contiguous
//  tx_last_o        out  1               final beat of packet
//  tx_ready_i       in   1               downstream accepts beat when tx_valid_o & tx_ready_i
//  drop_o           out  1               1-cycle pulse: illegal-size packet discarded
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, inflight_r=0; tx_valid_o, packet_ack_o, packet_rvalid_o,
//   drop_o, tx_last_o = 0; packet_raddr_o = 0. Reset mid-packet abandons it: no ack, no
//   further beats from cycle after reset; packet is restarted from byte 0 afterward.
//  FSM IDLE: if packet_avail_i: size==0 or size>els_p -> packet_ack_o=1 and drop_o=1 this
//   cycle, stay IDLE; else latch size_r, words_r=ceil(size/bytes_lp), raddr=0, -> STREAM.
//  FSM STREAM: packet_rvalid_o=1 when issued_r<words_r and (fifo_count_r+inflight_r)<3;
//   raddr advances by bytes_lp per issue. inflight_r <= packet_rvalid_o; when inflight_r=1,
//   packet_rdata_i is pushed into FIFO (tag last = word index == words_r-1). FIFO head drives
//   tx_*; tx_valid_o = fifo nonempty. Push and pop in same cycle both take effect.
//   On pop of the last-tagged beat -> DONE.
//  FSM DONE: packet_ack_o=1 for exactly one cycle, -> IDLE. IDLE samples next packet the
//   following cycle (buffer pointer has advanced). Steady-state throughput: 1 beat/cycle.
//  tx_keep_o: all ones on non-last beats; last beat = (1<<(size mod bytes_lp))-1, all ones
//   when size mod bytes_lp == 0. tx_valid_o, once high, holds data/keep/last stable until
//   accepted. No read is issued after the last word or outside STREAM.
//  packet_raddr_o never exceeds els_p-bytes_lp; issue counter is size_width_lp wide, no wrap.
//  packet_avail_i dropping mid-STREAM is a protocol error (sim assertion); FIFO overflow and
//   pop-when-empty are impossible by construction (sim assertions).
// TESTING
//  size=64, ready=1: reads at 0,8..56 back-to-back; 8 beats consecutive, keep=0xFF, last on
//   beat 8; packet_ack_o pulses exactly one cycle after beat 8 accepted.
//  size=13: 2 beats, keep 0xFF then 0x1F with last; size=1: 1 beat keep=0x01 last.
//  size=64, ready pattern 1,0,0,1,0,1...: data order intact, rvalid never asserted with
//   fifo_count+inflight==3, no beat lost or duplicated, tx_* stable while stalled.
//  size=0 and size=2049: drop_o and packet_ack_o pulse together in IDLE, tx_valid_o stays 0.
//  size=2048: 256 beats, final raddr=2040, last keep=0xFF; followed by size=8 packet: its
//   first read issues 3 cycles after the prior last beat (DONE, IDLE, STREAM).
//  reset_i asserted after 3 beats of 64-byte packet: next cycle tx_valid_o=0, no ack; after
//   release the same packet restarts at raddr 0 and completes normally.

Source files
------------

// File: rtl/packet_stream_reader.sv
// Reads packets word by word out of a packet_buffer read slot and streams them as
// valid/ready beats with byte keep and last. Illegal-size packets are acked and dropped.
module packet_stream_reader #(
   parameter int data_width_p = 64,
   parameter int els_p = 2048,
   localparam int addr_width_lp = $clog2(els_p),
   localparam int size_width_lp = $clog2(els_p+1),
   localparam int bytes_lp = data_width_p/8
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     packet_avail_i,
   input  logic [size_width_lp-1:0] packet_rsize_i,
   output logic                     packet_ack_o,
   output logic                     packet_rvalid_o,
   output logic [addr_width_lp-1:0] packet_raddr_o,
   input  logic [data_width_p-1:0]  packet_rdata_i,
   output logic                     tx_valid_o,
   output logic [data_width_p-1:0]  tx_data_o,
   output logic [bytes_lp-1:0]      tx_keep_o,
   output logic                     tx_last_o,
   input  logic                     tx_ready_i,
   output logic                     drop_o
);

   localparam int lg_bytes_lp = $clog2(bytes_lp);

   if (data_width_p != 32 && data_width_p != 64) begin : g_bad_width
      $error("packet_stream_reader: data_width_p must be 32 or 64");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} state_e;

   state_e                   state_r, state_n;
   logic [size_width_lp-1:0] words_r, issued_r, pushed_r;
   logic [lg_bytes_lp-1:0]   rem_r;
   logic [addr_width_lp-1:0] raddr_r;
   logic                     inflight_r;

   logic [data_width_p-1:0]  fifo_data_r [3];
   logic [2:0]               fifo_last_r;
   logic [1:0]               rd_ptr_r, wr_ptr_r, count_r;

   logic                     size_ok, start, issue, push, pop, head_last;
   logic [size_width_lp:0]   round_up;
   logic [size_width_lp-1:0] words_in;
   logic [bytes_lp-1:0]      keep_last;

   assign size_ok  = (packet_rsize_i != '0) &&
                     (packet_rsize_i <= size_width_lp'(els_p));
   assign round_up = {1'b0, packet_rsize_i} + (size_width_lp+1)'(bytes_lp-1);
   assign words_in = size_width_lp'(round_up >> lg_bytes_lp);

   // The issue window counts words already in the FIFO plus the one still in the RAM pipe.
   assign issue = (state_r == ST_STREAM) && (issued_r < words_r) &&
                  (({1'b0, count_r} + {2'b00, inflight_r}) < 3'd3);
   assign push  = inflight_r;
   assign pop   = tx_valid_o && tx_ready_i;
   assign head_last = fifo_last_r[rd_ptr_r];

   always_comb begin
      state_n      = state_r;
      packet_ack_o = 1'b0;
      drop_o       = 1'b0;
      start        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (packet_avail_i) begin
               if (!size_ok) begin
                  packet_ack_o = 1'b1;
                  drop_o       = 1'b1;
               end else begin
                  start   = 1'b1;
                  state_n = ST_STREAM;
               end
            end
         end
         ST_STREAM: begin
            if (pop && head_last) state_n = ST_DONE;
         end
         ST_DONE: begin
            packet_ack_o = 1'b1;
            state_n      = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r    <= ST_IDLE;
         words_r    <= '0;
         issued_r   <= '0;
         pushed_r   <= '0;
         rem_r      <= '0;
         raddr_r    <= '0;
         inflight_r <= 1'b0;
      end else begin
         state_r    <= state_n;
         inflight_r <= issue;
         if (start) begin
            words_r  <= words_in;
            rem_r    <= packet_rsize_i[lg_bytes_lp-1:0];
            issued_r <= '0;
            pushed_r <= '0;
            raddr_r  <= '0;
         end else begin
            if (issue) begin
               issued_r <= issued_r + size_width_lp'(1);
               // Hold the address on the final word so it never runs past the slot.
               if ((issued_r + size_width_lp'(1)) < words_r)
                  raddr_r <= raddr_r + addr_width_lp'(bytes_lp);
            end
            if (push) pushed_r <= pushed_r + size_width_lp'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push) wr_ptr_r <= (wr_ptr_r == 2'd2) ? 2'd0 : wr_ptr_r + 2'd1;
         if (pop)  rd_ptr_r <= (rd_ptr_r == 2'd2) ? 2'd0 : rd_ptr_r + 2'd1;
         count_r <= count_r + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_data_r[wr_ptr_r] <= packet_rdata_i;
         fifo_last_r[wr_ptr_r] <= (pushed_r == (words_r - size_width_lp'(1)));
      end
   end

   assign keep_last       = ~({bytes_lp{1'b1}} << rem_r);
   assign packet_rvalid_o = issue;
   assign packet_raddr_o  = raddr_r;
   assign tx_valid_o      = (count_r != 2'd0);
   assign tx_data_o       = fifo_data_r[rd_ptr_r];
   assign tx_last_o       = tx_valid_o && head_last;
   assign tx_keep_o       = (head_last && (rem_r != '0)) ? keep_last : {bytes_lp{1'b1}};

   assert property (@(posedge clk_i) disable iff (reset_i)
                    (state_r == ST_STREAM) |-> packet_avail_i)
      else $error("packet_avail_i dropped while streaming");
   assert property (@(posedge clk_i) disable iff (reset_i) push |-> (count_r != 2'd3))
      else $error("output FIFO overflow");
   assert property (@(posedge clk_i) disable iff (reset_i) pop |-> (count_r != 2'd0))
      else $error("output FIFO pop while empty");

endmodule

// File: tb/tb_packet_stream_reader.sv
// Bench for packet_stream_reader: a packet_buffer read-side model feeds packets and a
// negedge monitor compares every read and beat against packet-level expectations.
module tb_packet_stream_reader;

   localparam int W   = 64;
   localparam int ELS = 2048;
   localparam int AW  = 11;
   localparam int SW  = 12;
   localparam int B   = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          avail;
   logic [SW-1:0] rsize;
   logic          ack, rvalid, tx_valid, tx_last, drop;
   logic [AW-1:0] raddr;
   logic [W-1:0]  rdata = '0;
   logic [W-1:0]  tx_data;
   logic [B-1:0]  tx_keep;
   logic          tx_ready = 1'b1;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int rmode = 0;

   packet_stream_reader #(.data_width_p(W), .els_p(ELS)) dut (
      .clk_i(clk), .reset_i(reset), .packet_avail_i(avail), .packet_rsize_i(rsize),
      .packet_ack_o(ack), .packet_rvalid_o(rvalid), .packet_raddr_o(raddr),
      .packet_rdata_i(rdata), .tx_valid_o(tx_valid), .tx_data_o(tx_data),
      .tx_keep_o(tx_keep), .tx_last_o(tx_last), .tx_ready_i(tx_ready), .drop_o(drop)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // packet_buffer read-side model: a ring of slots, advanced by ack
   logic [SW-1:0] slot_size [256];
   logic [31:0]   slot_salt [256];
   logic [7:0]    wr_cnt = 8'd0;
   logic [7:0]    rd_cnt = 8'd0;

   assign avail = (wr_cnt != rd_cnt);
   assign rsize = slot_size[rd_cnt];

   function automatic logic [63:0] word_of(input int s, input int idx);
      return {slot_salt[s], s[7:0], 8'hC3, idx[15:0]};
   endfunction

   function automatic logic [7:0] keep_of(input int sz, input int idx);
      int words = (sz + B - 1) / B;
      int rem = sz % B;
      if (idx == words - 1 && rem != 0) return 8'((1 << rem) - 1);
      return 8'hFF;
   endfunction

   always @(posedge clk) begin
      if (rvalid) rdata <= word_of(int'(rd_cnt), int'(raddr) / B);
      if (!reset && ack) rd_cnt <= rd_cnt + 8'd1;
   end

   // driver tasks
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   int          r_done [256];
   int          r_beats [256];
   logic [7:0]  r_keep [256];
   logic        r_drop [256];
   int          r_ack_cyc [256];
   int          r_last_cyc [256];
   int          r_first_beat [256];
   int          r_first_rd [256];
   int          r_last_rd [256];
   int          r_last_raddr [256];

   task automatic push_pkt(input int sz, output int s);
      s = int'(wr_cnt);
      slot_size[s] = SW'(sz);
      slot_salt[s] = $urandom;
      r_done[s] = 0;
      r_beats[s] = 0;
      r_keep[s] = 8'h00;
      r_drop[s] = 1'b0;
      wr_cnt = wr_cnt + 8'd1;
   endtask

   task automatic wait_done(input int s, input int budget, input string name);
      for (int i = 0; i < budget && r_done[s] == 0; i++) @(posedge clk);
      check({name, "_completed"}, 64'(r_done[s]), 64'd1);
      @(posedge clk);
      #1;
   endtask

   // ready driver: 0 always ready, 1 fixed stall pattern, 2/3 random
   initial begin
      int pi = 0;
      logic [5:0] pat = 6'b101001;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0: tx_ready = 1'b1;
            1: begin tx_ready = pat[pi]; pi = (pi + 1) % 6; end
            2: tx_ready = ($urandom_range(0, 3) != 0);
            default: tx_ready = ($urandom_range(0, 1) != 0);
         endcase
      end
   end

   // scoreboard / monitor, sampled away from the active edge
   int          m_bcnt = 0, m_iss = 0;
   logic        stall_v = 1'b0;
   logic [W-1:0] held_data;
   logic [B-1:0] held_keep;
   logic        held_last;

   always @(negedge clk) begin
      int s, sz, words;
      logic legal;
      if (reset) begin
         m_bcnt = 0;
         m_iss = 0;
         stall_v = 1'b0;
      end else begin
         s = int'(rd_cnt);
         sz = int'(slot_size[s]);
         words = (sz + B - 1) / B;
         legal = (sz > 0) && (sz <= ELS);
         if (stall_v) begin
            check("hold_valid", 64'(tx_valid), 64'd1);
            check("hold_data", tx_data, held_data);
            check("hold_keep", 64'(tx_keep), 64'(held_keep));
            check("hold_last", 64'(tx_last), 64'(held_last));
         end
         if (rvalid) begin
            check("read_window", 64'((m_iss - m_bcnt) < 3), 64'd1);
            check("read_in_range", 64'(avail && m_iss < words), 64'd1);
            check("raddr", 64'(raddr), 64'(m_iss * B));
            if (m_iss == 0) r_first_rd[s] = cyc;
            r_last_rd[s] = cyc;
            r_last_raddr[s] = int'(raddr);
            m_iss++;
         end
         if (tx_valid && tx_ready) begin
            check("beat_data", tx_data, word_of(s, m_bcnt));
            check("beat_keep", 64'(tx_keep), 64'(keep_of(sz, m_bcnt)));
            check("beat_last", 64'(tx_last), 64'(m_bcnt == words - 1));
            if (m_bcnt == 0) r_first_beat[s] = cyc;
            if (tx_last) begin
               r_last_cyc[s] = cyc;
               r_keep[s] = tx_keep;
            end
            m_bcnt++;
         end
         if (drop && !ack) check("drop_with_ack", 64'(ack), 64'd1);
         if (ack) begin
            check("drop_flag", 64'(drop), 64'(!legal));
            if (legal) check("beats_at_ack", 64'(m_bcnt), 64'(words));
            r_beats[s] = m_bcnt;
            r_drop[s] = drop;
            r_ack_cyc[s] = cyc;
            r_done[s] = 1;
            m_bcnt = 0;
            m_iss = 0;
         end
         stall_v = tx_valid && !tx_ready;
         held_data = tx_data;
         held_keep = tx_keep;
         held_last = tx_last;
      end
   end

   typedef struct {
      int         size;
      int         beats;
      logic [7:0] keep;
      logic       drop;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int s, s2, sz, nrand;
      int rs [20];
      tbl[0] = '{64,   8,   8'hFF, 1'b0};
      tbl[1] = '{13,   2,   8'h1F, 1'b0};
      tbl[2] = '{1,    1,   8'h01, 1'b0};
      tbl[3] = '{0,    0,   8'h00, 1'b1};
      tbl[4] = '{2049, 0,   8'h00, 1'b1};
      tbl[5] = '{8,    1,   8'hFF, 1'b0};
      tbl[6] = '{7,    1,   8'h7F, 1'b0};
      tbl[7] = '{9,    2,   8'h01, 1'b0};
      tbl[8] = '{2047, 256, 8'h7F, 1'b0};
      tbl[9] = '{2048, 256, 8'hFF, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_tx_valid", 64'(tx_valid), 64'd0);
      check("reset_ack", 64'(ack), 64'd0);
      check("reset_rvalid", 64'(rvalid), 64'd0);
      check("reset_drop", 64'(drop), 64'd0);
      check("reset_last", 64'(tx_last), 64'd0);
      check("reset_raddr", 64'(raddr), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      for (int t = 0; t < 10; t++) begin
         push_pkt(tbl[t].size, s);
         wait_done(s, 2000, "tbl");
         check($sformatf("tbl%0d_beats", t), 64'(r_beats[s]), 64'(tbl[t].beats));
         check($sformatf("tbl%0d_drop", t), 64'(r_drop[s]), 64'(tbl[t].drop));
         if (tbl[t].beats > 0)
            check($sformatf("tbl%0d_last_keep", t), 64'(r_keep[s]), 64'(tbl[t].keep));
      end

      // 64 bytes at full rate: back-to-back reads and beats, ack right after the last beat
      push_pkt(64, s);
      wait_done(s, 200, "seq64");
      check("seq64_read_span", 64'(r_last_rd[s] - r_first_rd[s]), 64'd7);
      check("seq64_final_raddr", 64'(r_last_raddr[s]), 64'd56);
      check("seq64_beat_span", 64'(r_last_cyc[s] - r_first_beat[s]), 64'd7);
      check("seq64_ack_delay", 64'(r_ack_cyc[s] - r_last_cyc[s]), 64'd1);

      // 64 bytes under a fixed stall pattern
      rmode = 1;
      push_pkt(64, s);
      wait_done(s, 400, "stall64");
      check("stall64_beats", 64'(r_beats[s]), 64'd8);
      rmode = 0;

      // full slot followed by a short packet
      push_pkt(2048, s);
      push_pkt(8, s2);
      wait_done(s2, 2000, "full_then_short");
      check("full_beats", 64'(r_beats[s]), 64'd256);
      check("full_final_raddr", 64'(r_last_raddr[s]), 64'd2040);
      check("full_last_keep", 64'(r_keep[s]), 64'hFF);
      check("next_first_read_gap", 64'(r_first_rd[s2] - r_last_cyc[s]), 64'd3);

      // reset in the middle of a packet
      push_pkt(64, s);
      for (int i = 0; i < 100 && m_bcnt < 3; i++) @(posedge clk);
      check("mid_reset_reached_3_beats", 64'(m_bcnt >= 3), 64'd1);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("after_reset_tx_valid", 64'(tx_valid), 64'd0);
      check("after_reset_ack", 64'(ack), 64'd0);
      check("after_reset_done", 64'(r_done[s]), 64'd0);
      wait_done(s, 200, "restart64");
      check("restart64_beats", 64'(r_beats[s]), 64'd8);

      // randomized packets under random backpressure
      nrand = 20;
      for (int i = 0; i < nrand; i++) begin
         case ($urandom_range(0, 9))
            0: sz = 0;
            1: sz = $urandom_range(ELS + 1, 4095);
            2, 3: sz = $urandom_range(1, 24);
            4: sz = ELS - $urandom_range(0, 15);
            default: sz = $urandom_range(1, 300);
         endcase
         push_pkt(sz, rs[i]);
      end
      for (int i = 0; i < nrand; i++) begin
         rmode = 2 + (i % 2);
         wait_done(rs[i], 3000, "rand");
         sz = int'(slot_size[rs[i]]);
         if (sz == 0 || sz > ELS) begin
            check("rand_drop", 64'(r_drop[rs[i]]), 64'd1);
            check("rand_drop_beats", 64'(r_beats[rs[i]]), 64'd0);
         end else begin
            check("rand_drop", 64'(r_drop[rs[i]]), 64'd0);
            check("rand_beats", 64'(r_beats[rs[i]]), 64'((sz + B - 1) / B));
         end
      end
      rmode = 0;
      repeat (5) @(posedge clk);
      #1;
      check("buffer_drained", 64'(avail), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
